// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use stall, taken-branch flush, multi-cycle MUL hold.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs2_used_i,
    input  logic             id_mul_i,
    input  logic             branch_taken_i,
    input  logic             ex_MemRead_i,
    input  logic [4:0]       ex_rd_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             NoOp_o,
    output logic             Flush_o,
    output logic             mul_busy_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int CNT_BITS = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_BITS'(MUL_LAT - 2) : '0;

    if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_bad_mul_lat
        $error("hazard_ctrl: MUL_LAT must be in 1..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    logic                w_load_use;

    assign w_load_use = id_valid_i && ex_MemRead_i && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == id_rs1_i) || (id_rs2_used_i && (ex_rd_i == id_rs2_i)));

    // NOTE: every output and next-state signal gets a default before the case, so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        NoOp_o        = 1'b0;
        Flush_o       = 1'b0;
        mul_busy_o    = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_load_use) begin
                    // The load leaves EX next cycle, so a single bubble resolves it.
                    PCWrite_o     = 1'b0;
                    IF_ID_Write_o = 1'b0;
                    NoOp_o        = 1'b1;
                end else if (branch_taken_i) begin
                    Flush_o = 1'b1;
                end else if (id_valid_i && id_mul_i && (MUL_LAT > 1)) begin
                    w_state_nxt = S_MUL_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_MUL_BUSY: begin
                PCWrite_o     = 1'b0;
                IF_ID_Write_o = 1'b0;
                NoOp_o        = 1'b1;
                mul_busy_o    = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_BITS'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        // Reset forces a fully quiesced front end regardless of the current state.
        if (rst_i) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            NoOp_o        = 1'b1;
            Flush_o       = 1'b1;
            mul_busy_o    = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PCWrite_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (Flush_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

    a_no_flush_and_noop : assert property (@(posedge clk_i) disable iff (rst_i) !(Flush_o && NoOp_o))
        else $error("hazard_ctrl: Flush_o and NoOp_o asserted together");

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a remaining-stall-cycles model pushes expected output
// vectors {PCWrite, IF_ID_Write, NoOp, Flush, mul_busy} to a scoreboard that is popped at the negedge.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs2_used_i;
    logic       id_mul_i;
    logic       branch_taken_i;
    logic       ex_MemRead_i;
    logic [4:0] ex_rd_i;
    logic       PCWrite_o;
    logic       IF_ID_Write_o;
    logic       NoOp_o;
    logic       Flush_o;
    logic       mul_busy_o;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_mul_i       (id_mul_i),
        .branch_taken_i (branch_taken_i),
        .ex_MemRead_i   (ex_MemRead_i),
        .ex_rd_i        (ex_rd_i),
        .PCWrite_o      (PCWrite_o),
        .IF_ID_Write_o  (IF_ID_Write_o),
        .NoOp_o         (NoOp_o),
        .Flush_o        (Flush_o),
        .mul_busy_o     (mul_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         busy_left = 0;  // stall cycles still owed to an issued MUL
    logic [4:0] sb_q[$];
    string      tag_q[$];

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {pcw,ifid,noop,flush,busy}=%b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs and next model state, compare mid-cycle.
    task automatic step(input string tag, input logic rst, input logic valid,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic used,
                        input logic mul, input logic br, input logic memrd, input logic [4:0] rd);
        logic       lu;
        logic [4:0] exp;
        int         nb;
        rst_i          = rst;
        id_valid_i     = valid;
        id_rs1_i       = rs1;
        id_rs2_i       = rs2;
        id_rs2_used_i  = used;
        id_mul_i       = mul;
        branch_taken_i = br;
        ex_MemRead_i   = memrd;
        ex_rd_i        = rd;

        lu = valid && memrd && (rd != 5'd0) && ((rd == rs1) || (used && (rd == rs2)));
        if (rst) begin
            exp = 5'b00110;
            nb  = 0;
        end else if (busy_left > 0) begin
            exp = 5'b00101;
            nb  = busy_left - 1;
        end else if (lu) begin
            exp = 5'b00100;
            nb  = 0;
        end else begin
            exp = {1'b1, 1'b1, 1'b0, br, 1'b0};
            nb  = (!br && valid && mul && MUL_LAT > 1) ? MUL_LAT - 1 : 0;
        end
        sb_q.push_back(exp);
        tag_q.push_back(tag);

        @(negedge clk_i);
        check(tag_q.pop_front(), {PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, mul_busy_o},
              sb_q.pop_front());
        @(posedge clk_i);
        #1;
        busy_left = nb;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        // Reset held two cycles, then idle.
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle0");
        idle("idle1");

        // Load-use on rs1, released when the load leaves EX.
        step("lu_rs1", 0, 1, 5, 0, 0, 0, 0, 1, 5);
        step("lu_rel", 0, 1, 5, 0, 0, 0, 0, 0, 5);
        // x0 never hazards; an unused rs2 never hazards; a used rs2 does.
        step("lu_x0", 0, 1, 0, 0, 1, 0, 0, 1, 0);
        step("lu_rs2_unused", 0, 1, 1, 7, 0, 0, 0, 1, 7);
        step("lu_rs2_used", 0, 1, 1, 7, 1, 0, 0, 1, 7);
        step("lu_invalid", 0, 0, 5, 0, 0, 0, 0, 1, 5);

        // MUL issue followed by MUL_LAT-1 busy cycles that ignore load-use and branch.
        step("mul_issue", 0, 1, 1, 2, 1, 1, 0, 0, 0);
        step("mul_busy1", 0, 1, 3, 3, 1, 0, 1, 0, 0);
        step("mul_busy2", 0, 1, 3, 3, 1, 0, 0, 1, 3);
        step("mul_busy3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("mul_done");

        // Load-use wins over branch; branch flushes the next cycle.
        step("lu_br", 0, 1, 9, 0, 0, 0, 1, 1, 9);
        step("br_after", 0, 1, 9, 0, 0, 0, 1, 0, 9);

        // Back-to-back MULs: second issues on first RUN cycle after busy.
        for (int i = 0; i < 2 * MUL_LAT; i++) begin
            step($sformatf("mul_b2b%0d", i), 0, 1, 4, 4, 1, 1, 0, 0, 0);
        end
        idle("b2b_done");

        // Load-use on a MUL: stall first, MUL issues next cycle.
        step("lu_mul", 0, 1, 6, 0, 0, 1, 0, 1, 6);
        step("lu_mul_issue", 0, 1, 6, 0, 0, 1, 0, 0, 6);
        for (int i = 1; i < MUL_LAT; i++) begin
            idle($sformatf("lu_mul_busy%0d", i));
        end
        idle("lu_mul_done");

        // Reset during MUL busy aborts; RUN the cycle after.
        step("abort_issue", 0, 1, 1, 1, 0, 1, 0, 0, 0);
        idle("abort_busy1");
        step("abort_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("abort_run");
        idle("abort_run2");

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            logic br;
            br = ($urandom_range(0, 5) == 0);
            step($sformatf("rnd%0d", i), ($urandom_range(0, 40) == 0), $urandom_range(0, 1),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
                 (!br && ($urandom_range(0, 4) == 0)), br, $urandom_range(0, 1),
                 5'($urandom_range(0, 3)));
        end

        if (sb_q.size() != 0) begin
            check("sb_drain", 5'(sb_q.size()), 5'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
